// File: rtl/issue_busy_tracker.sv
// Busy/owner scoreboard between rename and operand read: RAW/WAW issue hold, writeback clear, stall counter.
// Optional feature: define BUSY_WB_BYPASS_EN to let a same-cycle writeback release a busy source operand.
module issue_busy_tracker #(
  parameter int unsigned NR_WB_PORTS   = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  instr_valid_i,
  input  logic [5:0]                            rs1_i,
  input  logic [5:0]                            rs2_i,
  input  logic [5:0]                            rs3_i,
  input  logic [1:0]                            rs1_rf_i,
  input  logic [1:0]                            rs2_rf_i,
  input  logic [1:0]                            rs3_rf_i,
  input  logic [5:0]                            rd_i,
  input  logic [1:0]                            rd_rf_i,
  input  logic [TRANS_ID_BITS-1:0]              trans_id_i,
  output logic                                  issue_ack_o,
  output logic                                  issue_valid_o,
  input  logic                                  issue_ack_i,
  input  logic [NR_WB_PORTS-1:0]                wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]  wb_trans_id_i,
  output logic                                  hazard_o,
  output logic [STALL_CNT_W-1:0]                stall_cnt_o
);

  localparam int unsigned NR_FILES = 3;
  localparam int unsigned NR_REGS  = 64;
  localparam logic [1:0]  RF_NONE  = 2'b11;
  localparam logic [1:0]  RF_GPR   = 2'b00;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  typedef logic [TRANS_ID_BITS-1:0] tid_t;

  logic busy_q  [NR_FILES][NR_REGS];
  tid_t owner_q [NR_FILES][NR_REGS];
  logic rd_set_c;

  // True when any valid writeback port carries this transaction id.
  function automatic logic wb_hit(input tid_t id);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k] && (wb_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS] == id)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic entry_busy(input logic [1:0] rf, input logic [5:0] addr);
    logic b;
    b = 1'b0;
    if (rf != RF_NONE) b = busy_q[rf][addr];
    return b;
  endfunction

  function automatic logic src_busy(input logic [1:0] rf, input logic [5:0] addr);
    logic b;
    b = 1'b0;
    if (rf != RF_NONE) begin
      b = busy_q[rf][addr];
`ifdef BUSY_WB_BYPASS_EN
      if (wb_hit(owner_q[rf][addr])) b = 1'b0;
`endif
    end
    return b;
  endfunction

  // Destination check (WAW) never uses the writeback bypass.
  always_comb begin
    hazard_o      = 1'b0;
    issue_valid_o = 1'b0;
    issue_ack_o   = 1'b0;
    rd_set_c      = 1'b0;
    hazard_o      = instr_valid_i & (src_busy(rs1_rf_i, rs1_i) | src_busy(rs2_rf_i, rs2_i) |
                                     src_busy(rs3_rf_i, rs3_i) | entry_busy(rd_rf_i, rd_i));
    issue_valid_o = instr_valid_i & ~hazard_o & ~flush_i;
    issue_ack_o   = issue_ack_i & issue_valid_o;
    rd_set_c      = issue_ack_o & (rd_rf_i != RF_NONE) & ~((rd_rf_i == RF_GPR) & (rd_i == 6'h00));
  end

  // Writeback clears first; a same-cycle issue to the entry overrides (later NBA wins).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned f = 0; f < NR_FILES; f++) begin
        for (int unsigned r = 0; r < NR_REGS; r++) begin
          busy_q[f][r]  <= 1'b0;
          owner_q[f][r] <= '0;
        end
      end
    end else if (flush_i) begin
      for (int unsigned f = 0; f < NR_FILES; f++) begin
        for (int unsigned r = 0; r < NR_REGS; r++) begin
          busy_q[f][r] <= 1'b0;
        end
      end
    end else begin
      for (int unsigned f = 0; f < NR_FILES; f++) begin
        for (int unsigned r = 0; r < NR_REGS; r++) begin
          if (busy_q[f][r] && wb_hit(owner_q[f][r])) busy_q[f][r] <= 1'b0;
        end
      end
      if (rd_set_c) begin
        busy_q[rd_rf_i][rd_i]  <= 1'b1;
        owner_q[rd_rf_i][rd_i] <= trans_id_i;
      end
    end
  end

  // Saturating hazard-cycle counter; flush cycles are not counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (hazard_o && !flush_i && (stall_cnt_o != STALL_MAX)) begin
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

endmodule
